seq_detect_prog: RTL and testbench

//  Parametrised serial pattern detector, successor to the fixed 4-bit "1001" FSM detector.

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_detect_if.sv | 47 ++++
 rtl/seq_hist_shreg.sv | 38 +++
 rtl/seq_detect_prog.sv | 108 ++++++++++
 tb/tb_seq_detect_prog.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
// Optional match counter is built when SEQ_DET_CNT_EN is defined.
package seq_detect_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        DETECT = 2'd2
    } state_e;

endpackage

// File: rtl/seq_detect_if.sv
// Control/data bundle between the bit sampler (master) and the detector (slave).
// Counter signals exist only when SEQ_DET_CNT_EN is defined.
interface seq_detect_if
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
`ifdef SEQ_DET_CNT_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
);
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             en;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             din;
    logic             din_valid;
    logic             match;
    logic             busy;
`ifdef SEQ_DET_CNT_EN
    logic             cnt_clr;
    logic [CNT_W-1:0] match_cnt;
`endif

    modport master (
        output en, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output din, din_valid,
`ifdef SEQ_DET_CNT_EN
        output cnt_clr,
        input  match_cnt,
`endif
        input  match, busy
    );

    modport slave (
        input  en, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  din, din_valid,
`ifdef SEQ_DET_CNT_EN
        input  cnt_clr,
        output match_cnt,
`endif
        output match, busy
    );

endinterface

// File: rtl/seq_hist_shreg.sv
// Bit history shift register with a saturating fill counter.
// Clear has priority over shift.
module seq_hist_shreg
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             din_i,
    output logic [PAT_W-1:0] hist_o,
    output logic [LEN_W-1:0] fill_o
);

    logic [PAT_W-1:0] hist_q;
    logic [LEN_W-1:0] fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_i) begin
            hist_q <= {hist_q[PAT_W-2:0], din_i};
            if (fill_q != LEN_W'(PAT_W))
                fill_q <= fill_q + LEN_W'(1);
        end
    end

    assign hist_o = hist_q;
    assign fill_o = fill_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: config registers, FSM, masked compare.
// Define SEQ_DET_CNT_EN to add the saturating match counter.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
`ifdef SEQ_DET_CNT_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_detect_if.slave bus
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    state_e           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic             match_q;

    logic [PAT_W-1:0] hist;
    logic [LEN_W-1:0] fill;
    logic [PAT_W-1:0] cand;
    logic [PAT_W-1:0] mask;
    logic             accept;
    logic             armed;
    logic             hit;
    logic             hist_clr;
    logic             unused_hist_msb;

    assign accept = bus.en & bus.din_valid & ~bus.cfg_load;
    assign cand   = {hist[PAT_W-2:0], bus.din};
    assign unused_hist_msb = hist[PAT_W-1];

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++)
            mask[i] = (i < int'(len_q));
    end

    // Armed once the incoming bit completes len bits of history.
    assign armed = (len_q != '0) && (int'(fill) + 1 >= int'(len_q));
    assign hit   = accept & armed & (((cand ^ pat_q) & mask) == '0);

    assign hist_clr = ~bus.en | bus.cfg_load | (hit & ~ovl_q);

    seq_hist_shreg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_hist (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (hist_clr),
        .shift_i (accept),
        .din_i   (bus.din),
        .hist_o  (hist),
        .fill_o  (fill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            match_q <= hit;
            if (bus.cfg_load) begin
                pat_q   <= bus.cfg_pattern;
                len_q   <= (int'(bus.cfg_len) > PAT_W) ?
                           LEN_W'(PAT_W) : bus.cfg_len;
                ovl_q   <= bus.cfg_overlap;
                state_q <= bus.en ? FILL : IDLE;
            end else if (!bus.en) begin
                state_q <= IDLE;
            end else if (hit && !ovl_q) begin
                state_q <= FILL;
            end else if (accept && armed) begin
                state_q <= DETECT;
            end else if (state_q == IDLE) begin
                state_q <= FILL;
            end
        end
    end

    assign bus.match = match_q;
    assign bus.busy  = (state_q != IDLE);

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (bus.cnt_clr)
            cnt_q <= '0;
        else if (match_q && cnt_q != '1)
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: directed scenarios then random traffic
// against a bit-queue reference model.
module tb_seq_detect_prog;

    localparam int PW = 8;
    localparam int CW = 2;
    localparam int LW = $clog2(PW + 1);

    typedef struct {
        logic match;
        logic busy;
        int   cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   cyc;
    exp_t exp_q[$];

    bit          hq[$];
    bit [PW-1:0] m_pat;
    int          m_len;
    bit          m_ovl;
    bit          m_busy;
    bit          m_match;
    int          m_cnt;
    int          fp;

`ifdef SEQ_DET_CNT_EN
    seq_detect_if #(.PAT_W(PW), .CNT_W(CW)) sif ();
    seq_detect_prog #(.PAT_W(PW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );
`else
    seq_detect_if #(.PAT_W(PW)) sif ();
    seq_detect_prog #(.PAT_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (sif.match !== e.match || sif.busy !== e.busy) begin
                fails++;
                $display("FAIL match_busy cyc=%0d got %b/%b exp %b/%b",
                         cyc, sif.match, sif.busy, e.match, e.busy);
            end
`ifdef SEQ_DET_CNT_EN
            tests++;
            if (int'(sif.match_cnt) != e.cnt) begin
                fails++;
                $display("FAIL match_cnt cyc=%0d got %0d exp %0d",
                         cyc, sif.match_cnt, e.cnt);
            end
`endif
        end
    end

    task automatic step(input bit r, input bit e, input bit ld,
                        input bit [PW-1:0] p, input bit [LW-1:0] l,
                        input bit o, input bit d, input bit v,
                        input bit cc);
        exp_t x;
        bit   nm;
        bit   ok;
        @(negedge clk);
        #1;
        rst_n           = r;
        sif.en          = e;
        sif.cfg_load    = ld;
        sif.cfg_pattern = p;
        sif.cfg_len     = l;
        sif.cfg_overlap = o;
        sif.din         = d;
        sif.din_valid   = v;
`ifdef SEQ_DET_CNT_EN
        sif.cnt_clr     = cc;
`endif
        nm = 1'b0;
        if (!r) begin
            hq.delete();
            m_pat = '0; m_len = 0; m_ovl = 0;
            m_busy = 0; m_cnt = 0;
        end else begin
            if (cc)
                m_cnt = 0;
            else if (m_match && m_cnt < (1 << CW) - 1)
                m_cnt++;
            if (ld) begin
                m_pat  = p;
                m_len  = (int'(l) > PW) ? PW : int'(l);
                m_ovl  = o;
                m_busy = e;
                hq.delete();
            end else if (!e) begin
                m_busy = 0;
                hq.delete();
            end else begin
                m_busy = 1;
                if (v) begin
                    hq.push_back(d);
                    if (hq.size() > PW) void'(hq.pop_front());
                    if (m_len != 0 && hq.size() >= m_len) begin
                        ok = 1;
                        for (int i = 0; i < m_len; i++)
                            if (hq[hq.size() - 1 - i] != m_pat[i]) ok = 0;
                        if (ok) begin
                            nm = 1;
                            if (!m_ovl) hq.delete();
                        end
                    end
                end
            end
        end
        m_match = nm;
        x.match = nm;
        x.busy  = m_busy;
        x.cnt   = m_cnt;
        exp_q.push_back(x);
    endtask

    task automatic load(input bit [PW-1:0] p, input int l, input bit o,
                        input bit d, input bit v);
        step(1, 1, 1, p, LW'(l), o, d, v, 0);
    endtask

    task automatic send(input bit [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--)
            step(1, 1, 0, '0, '0, 0, bits[i], 1, 0);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++)
            step(1, 1, 0, '0, '0, 0, 1'($urandom), 0, 0);
    endtask

    initial begin
        bit [PW-1:0] rp;
        int          rl;
        bit          d;
        tests = 0; fails = 0; cyc = 0; fp = 0;
        m_match = 0; m_cnt = 0; m_busy = 0; m_len = 0;
        rst_n = 1'b0;
        sif.en = 0; sif.cfg_load = 0; sif.cfg_pattern = '0;
        sif.cfg_len = '0; sif.cfg_overlap = 0;
        sif.din = 0; sif.din_valid = 0;
`ifdef SEQ_DET_CNT_EN
        sif.cnt_clr = 0;
`endif
        repeat (3) step(0, 0, 0, '0, '0, 0, 0, 0, 0);
        step(1, 0, 0, '0, '0, 0, 0, 0, 0);

        load(8'h09, 4, 1, 0, 0);
        send(16'b1001001, 7);
        load(8'h09, 4, 0, 0, 0);
        send(16'b1001001, 7);
        load(8'h09, 4, 1, 0, 0);
        send(16'b100, 3);
        gap(3);
        send(16'b1, 1);
        gap(2);

        load(8'h09, 4, 1, 0, 0);
        send(16'b10010, 5);
        load(8'hA5, 8, 1, 1, 1);
        send(16'hA5, 8);

        load(8'h00, 0, 1, 0, 0);
        send(16'h0000, 16);
        load(8'hA5, 12, 0, 0, 0);
        send(16'hA5A5, 16);

        load(8'h09, 4, 1, 0, 0);
        send(16'b10, 2);
        repeat (2) step(0, 1, 0, '0, '0, 0, 1, 1, 0);
        step(1, 1, 0, '0, '0, 0, 0, 0, 0);
        send(16'b1001, 4);
        load(8'h09, 4, 0, 0, 0);
        send(16'b1001, 4);
        for (int k = 0; k < 5; k++) send(16'b1001, 4);
        gap(2);
        step(1, 1, 0, '0, '0, 0, 0, 0, 1);
        gap(2);
        step(1, 0, 0, '0, '0, 0, 1, 1, 0);
        gap(1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                step(0, 1'($urandom), 1'($urandom), '0, '0, 0, 0, 1, 0);
                continue;
            end
            if ($urandom_range(0, 29) == 0) begin
                rp = PW'($urandom);
                rl = ($urandom_range(0, 3) == 0) ?
                     $urandom_range(0, 15) : $urandom_range(1, 4);
                fp = 0;
                step(1, $urandom_range(0, 9) != 0, 1, rp, LW'(rl),
                     1'($urandom), 1'($urandom), 1'($urandom), 0);
                continue;
            end
            if (m_len != 0 && $urandom_range(0, 3) != 0) begin
                d = m_pat[m_len - 1 - (fp % m_len)];
                fp = (fp + 1) % m_len;
            end else begin
                d = 1'($urandom);
            end
            step(1, $urandom_range(0, 39) != 0, 0, PW'($urandom),
                 LW'($urandom), 1'($urandom), d,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 49) == 0);
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++)
            @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
